// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl
// Description : Bit-serial add/subtract sequencer. Operands are stepped LSB
//               first through a single 1-bit full-adder cell with the carry
//               fed back through a flip-flop; the WIDTH-bit result, carry-out
//               and signed overflow are registered on the last bit step.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout,
    output logic             overflow
);

    localparam int                 C_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic [C_CNT_W-1:0] r_count;

    logic [WIDTH-1:0]   r_sum_out;
    logic               r_cout;
    logic               r_overflow;

    logic               w_s;
    logic               w_co;
    logic [WIDTH-1:0]   w_sum_next;
    logic               w_last;

    // The one and only full-adder cell: {carry, sum} of three input bits.
    function automatic logic [1:0] fa_cell(input logic x, input logic y, input logic c);
        fa_cell = {(x & y) | (x & c) | (y & c), x ^ y ^ c};
    endfunction

    // Current bit step: LSBs of the operand shifters plus the fed-back carry.
    always_comb begin
        {w_co, w_s} = fa_cell(r_a[0], r_b[0], r_carry);
        w_sum_next  = {w_s, r_sum[WIDTH-1:1]};
        w_last      = (r_count == C_LAST);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_RUN;
            S_RUN:   if (w_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Operand load, bit stepping and result capture on the final bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_sum      <= '0;
            r_carry    <= 1'b0;
            r_count    <= '0;
            r_sum_out  <= '0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // Subtraction is A + ~B + 1: invert B, seed carry with 1.
                        r_a     <= a_in;
                        r_b     <= sub ? ~b_in : b_in;
                        r_carry <= sub;
                        r_count <= '0;
                        r_sum   <= '0;
                    end
                end
                S_RUN: begin
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_sum   <= w_sum_next;
                    r_carry <= w_co;
                    r_count <= r_count + C_CNT_W'(1);
                    if (w_last) begin
                        // On the MSB step r_carry is the carry into the MSB,
                        // so signed overflow is its XOR with the carry out.
                        r_sum_out  <= w_sum_next;
                        r_cout     <= w_co;
                        r_overflow <= r_carry ^ w_co;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status flags are decoded straight from the state register.
    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign sum_out  = r_sum_out;
    assign cout     = r_cout;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder_ctrl
// Description : Directed bench for serial_adder_ctrl at WIDTH=8 plus an
//               exhaustive WIDTH=4 sweep against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ov;
    } exp_t;

    logic       clk;
    logic       rst;

    logic       start8, sub8, busy8, done8, cout8, ov8;
    logic [7:0] a8, b8, sum8;

    logic       start4, sub4, busy4, done4, cout4, ov4;
    logic [3:0] a4, b4, sum4;

    int   vectors;
    int   miscompares;
    exp_t sb8[$];
    exp_t sb4[$];

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8),
        .a_in(a8), .b_in(b8), .busy(busy8), .done(done8),
        .sum_out(sum8), .cout(cout8), .overflow(ov8)
    );

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .sub(sub4),
        .a_in(a4), .b_in(b4), .busy(busy4), .done(done4),
        .sum_out(sum4), .cout(cout4), .overflow(ov4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model in plain integer arithmetic.
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b, input bit s);
        exp_t   e;
        longint mask, ua, ub, r, sa, sb, sr, half;
        mask   = (64'sd1 <<< w) - 1;
        half   = 64'sd1 <<< (w - 1);
        ua     = longint'(a) & mask;
        ub     = longint'(b) & mask;
        r      = s ? (ua - ub) : (ua + ub);
        e.sum  = 32'(r & mask);
        e.cout = s ? (ua >= ub) : (((r >>> w) & 1) != 0);
        sa     = (ua >= half) ? ua - (half * 2) : ua;
        sb     = (ub >= half) ? ub - (half * 2) : ub;
        sr     = s ? (sa - sb) : (sa + sb);
        e.ov   = (sr > half - 1) || (sr < -half);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 operation; entered and left just after a rising edge in IDLE.
    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b, input bit s);
        exp_t       e;
        int         edges, bcnt;
        bit         got, moved;
        logic [7:0] prev;
        prev = sum8;
        sb8.push_back(model(8, 32'(a), 32'(b), s));
        a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        edges = 1; bcnt = 0; got = 0; moved = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done8) begin got = 1; break; end
            if (busy8) bcnt++;
            if (sum8 !== prev) moved = 1;
            @(posedge clk); edges++;
        end
        chk({tag, " done seen"}, 64'(got), 64'd1);
        e = sb8.pop_front();
        if (got) begin
            chk({tag, " latency"}, 64'(edges), 64'd9);
            chk({tag, " busy cycles"}, 64'(bcnt), 64'd8);
            chk({tag, " busy with done"}, 64'(busy8), 64'd0);
            chk({tag, " prior result held"}, 64'(moved), 64'd0);
            chk({tag, " sum"}, 64'(sum8), 64'(e.sum[7:0]));
            chk({tag, " cout"}, 64'(cout8), 64'(e.cout));
            chk({tag, " overflow"}, 64'(ov8), 64'(e.ov));
        end
        @(posedge clk); #1;
        chk({tag, " done one cycle"}, 64'(done8), 64'd0);
        chk({tag, " sum holds"}, 64'(sum8), 64'(e.sum[7:0]));
    endtask

    // One WIDTH=4 operation for the exhaustive sweep.
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input bit s);
        exp_t e;
        bit   got;
        sb4.push_back(model(4, 32'(a), 32'(b), s));
        a4 = a; b4 = b; sub4 = s; start4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done4) begin got = 1; break; end
            @(posedge clk);
        end
        e = sb4.pop_front();
        chk($sformatf("w4 a=%0h b=%0h sub=%0d", a, b, s),
            got ? 64'({sum4, cout4, ov4}) : 64'hDEAD,
            64'({e.sum[3:0], e.cout, e.ov}));
        @(posedge clk); #1;
    endtask

    initial begin
        exp_t e;
        int   dcnt;
        int   times[$];
        vectors = 0; miscompares = 0;
        rst = 1'b1;
        start8 = 0; sub8 = 0; a8 = 0; b8 = 0;
        start4 = 0; sub4 = 0; a4 = 0; b4 = 0;
        repeat (3) @(posedge clk);
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
        @(posedge clk); #1;
        chk("reset busy", 64'(busy8), 64'd0);
        chk("reset done", 64'(done8), 64'd0);
        chk("reset outputs", 64'({sum8, cout8, ov8}), 64'd0);
        chk("reset w4 outputs", 64'({busy4, done4, sum4, cout4, ov4}), 64'd0);
        start8 = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        chk("start during reset ignored", 64'(busy8), 64'd0);

        run8("add 3c+05", 8'h3C, 8'h05, 1'b0);
        run8("add ff+01", 8'hFF, 8'h01, 1'b0);
        run8("add 7f+01", 8'h7F, 8'h01, 1'b0);
        run8("sub 05-07", 8'h05, 8'h07, 1'b1);
        run8("sub 80-01", 8'h80, 8'h01, 1'b1);

        // Inputs wiggle and start pulses throughout RUN; only the sampled op counts.
        sb8.push_back(model(8, 32'h10, 32'h20, 1'b0));
        a8 = 8'h10; b8 = 8'h20; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done8) dcnt++;
            a8 = 8'($urandom); b8 = 8'($urandom); sub8 = ~sub8; start8 = ~start8;
            @(posedge clk); #1;
        end
        start8 = 1'b0;
        e = sb8.pop_front();
        chk("ignore done pulse", 64'(done8), 64'd1);
        chk("ignore sum", 64'(sum8), 64'(e.sum[7:0]));
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (done8) dcnt++;
        end
        chk("ignore single done", 64'(dcnt), 64'd0);
        chk("ignore sum held", 64'(sum8), 64'h30);
        run8("add 40+02", 8'h40, 8'h02, 1'b0);

        // Reset lands on the third RUN cycle.
        a8 = 8'h33; b8 = 8'h44; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("midrst busy", 64'(busy8), 64'd0);
        chk("midrst done", 64'(done8), 64'd0);
        chk("midrst outputs", 64'({sum8, cout8, ov8}), 64'd0);
        dcnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done8 || busy8) dcnt++;
        end
        chk("midrst no late activity", 64'(dcnt), 64'd0);
        @(posedge clk); #1;
        run8("add 01+01", 8'h01, 8'h01, 1'b0);

        // start held high: one acceptance every WIDTH+2 cycles.
        a8 = 8'h11; b8 = 8'h22; sub8 = 1'b0; start8 = 1'b1;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk);
            if (k == 31) begin #1 start8 = 1'b0; end
            @(negedge clk);
            if (done8) begin
                times.push_back(k);
                chk($sformatf("b2b sum #%0d", times.size()), 64'(sum8), 64'h33);
            end
        end
        chk("b2b done count", 64'(times.size()), 64'd4);
        for (int i = 1; i < times.size(); i++)
            chk($sformatf("b2b spacing #%0d", i), 64'(times[i] - times[i-1]), 64'd10);
        @(posedge clk); #1;

        // Exhaustive WIDTH=4 sweep.
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    run4(4'(a), 4'(b), s[0]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
